// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, widths
// and the rotating-priority scan used for every grant decision.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Returns {found, idx}: first set request in order last+1, last+2, last+3, last.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = {1'b0, {SEL_W{1'b0}}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = last + SEL_W'(k + 1);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain 4-to-1 single-bit multiplexer shared by the arbitrated requesters.
module mux_4to1
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] data,
    input  logic [SEL_W-1:0]   select,
    output logic               mux_o
);

    // Select one data bit by index.
    always_comb begin
        mux_o = 1'b0;
        case (select)
            2'd0:    mux_o = data[0];
            2'd1:    mux_o = data[1];
            2'd2:    mux_o = data[2];
            2'd3:    mux_o = data[3];
            default: mux_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter time-sharing one mux_4to1 among four requesters, with each
// tenure bounded to MAX_HOLD cycles so no requester can starve the others.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               out,
    output logic               out_valid
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [0:0]         state_q,    state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]   last_q,     last_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [SEL_W-1:0]   select_q,   select_d;

    logic [SEL_W-1:0]   scan_last_s;
    logic [SEL_W:0]     pick_s;
    logic               release_s;
    logic               mux_o_s;

    // Next-state: idle/grant decisions, tenure counting and hand-off.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        select_d    = select_q;
        release_s   = 1'b0;
        // While granted the current owner is the lowest-priority slot in the scan.
        scan_last_s = (state_q == GRANT) ? select_q : last_q;
        pick_s      = rr_pick(req, scan_last_s);
        case (state_q)
            IDLE: begin
                if (pick_s[SEL_W]) begin
                    state_d    = GRANT;
                    grant_d    = onehot(pick_s[SEL_W-1:0]);
                    select_d   = pick_s[SEL_W-1:0];
                    last_d     = pick_s[SEL_W-1:0];
                    hold_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d    = IDLE;
                    grant_d    = {NUM_REQ{1'b0}};
                end
            end
            GRANT: begin
                release_s = !req[select_q] || (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
                if (release_s) begin
                    hold_cnt_d = {CNT_W{1'b0}};
                    if (pick_s[SEL_W]) begin
                        state_d  = GRANT;
                        grant_d  = onehot(pick_s[SEL_W-1:0]);
                        select_d = pick_s[SEL_W-1:0];
                        last_d   = pick_s[SEL_W-1:0];
                    end else begin
                        state_d  = IDLE;
                        grant_d  = {NUM_REQ{1'b0}};
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = {NUM_REQ{1'b0}};
                hold_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; reset leaves requester 0 as the first winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= {CNT_W{1'b0}};
            last_q     <= 2'b11;
            grant_q    <= {NUM_REQ{1'b0}};
            select_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            select_q   <= select_d;
        end
    end

    mux_4to1 u_mux (
        .data   (data),
        .select (select_q),
        .mux_o  (mux_o_s)
    );

    assign grant     = grant_q;
    assign select    = select_q;
    assign out_valid = |grant_q;
    assign out       = mux_o_s & out_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: three instances (MAX_HOLD 8, 2, 1) share stimulus and
// are checked each cycle against a tenure-level model plus literal expectations.
module tb_mux_rr_arbiter;

    typedef struct packed {
        int own;
        int held;
        int last;
        int sel;
    } mst_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] data;

    logic [3:0] g [3];
    logic [1:0] s [3];
    logic       o [3];
    logic       v [3];

    int   hmax [3] = '{8, 2, 1};
    mst_t mst  [3];

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] vr [10] = '{4'b0011, 4'b1010, 4'b0110, 4'b1111, 4'b0001,
                            4'b1000, 4'b1100, 4'b0101, 4'b0000, 4'b1110};
    logic [3:0] vd [10] = '{4'b0001, 4'b1000, 4'b0110, 4'b1010, 4'b1111,
                            4'b0000, 4'b0100, 4'b0101, 4'b1111, 4'b0011};

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .grant(g[0]), .select(s[0]), .out(o[0]), .out_valid(v[0]));
    mux_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .grant(g[1]), .select(s[1]), .out(o[1]), .out_valid(v[1]));
    mux_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .grant(g[2]), .select(s[2]), .out(o[2]), .out_valid(v[2]));

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Tenure-level model: owner, cycles held so far, rotation pointer, visible select.
    function automatic mst_t mstep(input logic [3:0] r, input int h, input mst_t st);
        mst_t n;
        int   w;
        n = st;
        if (st.own < 0) begin
            w = pick(r, st.last);
            if (w >= 0) begin
                n.own = w; n.held = 1; n.last = w; n.sel = w;
            end
        end else if (!r[st.own] || st.held >= h) begin
            w = pick(r, st.own);
            if (w >= 0) begin
                n.own = w; n.held = 1; n.last = w; n.sel = w;
            end else begin
                n.own = -1; n.held = 0;
            end
        end else begin
            n.held = st.held + 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int m, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int m = 0; m < 3; m++) begin
            if (reset) mst[m] <= '{own: -1, held: 0, last: 3, sel: 0};
            else       mst[m] <= mstep(req, hmax[m], mst[m]);
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            chk("model_grant", m, int'(g[m]), (mst[m].own < 0) ? 0 : (1 << mst[m].own));
            chk("model_select", m, int'(s[m]), mst[m].sel);
            chk("model_valid", m, int'(v[m]), (mst[m].own < 0) ? 0 : 1);
            chk("model_out", m, int'(o[m]), (mst[m].own < 0) ? 0 : int'(data[mst[m].own]));
        end
    end

    task automatic apply(input logic [3:0] r, input logic [3:0] d);
        #1;
        req  = r;
        data = d;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        data  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk("rst_grant", m, int'(g[m]), 0);
            chk("rst_select", m, int'(s[m]), 0);
            chk("rst_valid", m, int'(v[m]), 0);
        end
        #1 reset = 1'b0;
        @(negedge clk);

        // Single requester 2: one-cycle latency, data passes through.
        apply(4'b0100, 4'b0100);
        for (int m = 0; m < 3; m++) begin
            chk("req2_grant", m, int'(g[m]), 4);
            chk("req2_select", m, int'(s[m]), 2);
            chk("req2_out", m, int'(o[m]), 1);
            chk("req2_valid", m, int'(v[m]), 1);
        end
        for (int c = 0; c < 20; c++) begin
            apply(4'b0100, 4'b0100);
            for (int m = 0; m < 3; m++) chk("hold2_grant", m, int'(g[m]), 4);
        end

        // Async reset mid-tenure drops grant without a clock edge.
        #1 reset = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("arst_grant", m, int'(g[m]), 0);
            chk("arst_valid", m, int'(v[m]), 0);
            chk("arst_out", m, int'(o[m]), 0);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1111;
        data  = 4'b0101;
        @(negedge clk);
        for (int m = 0; m < 3; m++) chk("post_rst_grant", m, int'(g[m]), 1);
        chk("post_rst_out", 0, int'(o[0]), 1);

        // All requesting: MAX_HOLD 2 pairs, MAX_HOLD 1 rotates every cycle.
        for (int i = 1; i < 10; i++) begin
            apply(4'b1111, 4'b0101);
            chk("rot2_grant", 1, int'(g[1]), 1 << ((i / 2) % 4));
            chk("rot2_select", 1, int'(s[1]), (i / 2) % 4);
            chk("rot1_grant", 2, int'(g[2]), 1 << (i % 4));
            chk("rot8_grant", 0, int'(g[0]), (i < 8) ? 1 : 2);
        end

        // Owner 1 drops while 0 and 3 request: 3 wins, no idle bubble.
        #1 reset = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0010;
        data  = 4'b0010;
        @(negedge clk);
        for (int m = 0; m < 3; m++) chk("own1_grant", m, int'(g[m]), 2);
        apply(4'b1001, 4'b0001);
        for (int m = 0; m < 3; m++) begin
            chk("handoff_grant", m, int'(g[m]), 8);
            chk("handoff_select", m, int'(s[m]), 3);
            chk("handoff_out", m, int'(o[m]), 0);
        end

        // No requests: idle with output gated, select retained.
        apply(4'b0000, 4'b1111);
        for (int m = 0; m < 3; m++) begin
            chk("idle_grant", m, int'(g[m]), 0);
            chk("idle_out", m, int'(o[m]), 0);
            chk("idle_valid", m, int'(v[m]), 0);
            chk("idle_select", m, int'(s[m]), 3);
        end

        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 3; c++) apply(vr[i], vd[i]);
        end
        apply(4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
